// File: rtl/clause_register_bank.sv
// ---------------------------------------------------------------------------
// clause_register_bank
//   Stores up to NUMBER_OF_CLAUSES clause coefficient vectors. Each slot is
//   written by index and has its own valid bit. On in_start_scan the valid
//   clauses are streamed in ascending index order over a valid/ready
//   handshake, one clause per cycle when the consumer is always ready.
//
//   Optional build macro: CLAUSE_REGISTER_BANK_CONTINUOUS_SCAN_EN
//     When defined, the handshake on the last clause wraps back to the lowest
//     valid slot. The scan then ends only on in_stop_scan, or when no valid
//     slot is left at wrap time.
//
// Ports
//   in_clk, in_reset_n          clock (rising edge), async active-low reset
//   in_write_enable/_index      write strobe and target slot (out-of-range
//   in_clause_coefficients      indices are ignored), data to store
//   in_clear                    invalidate every slot (IDLE only)
//   in_start_scan/in_stop_scan  begin (IDLE only) / abort a scan
//   in_out_ready                downstream accepts the presented clause
//   out_clause_coefficients     presented clause data
//   out_clause_index            presented clause index
//   out_valid, out_last         presented clause valid / highest valid index
//   out_busy, out_scan_done     scan in progress / one-cycle end-of-scan pulse
//   out_valid_count             number of valid slots
// ---------------------------------------------------------------------------
module clause_register_bank #(
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int NUMBER_OF_INTEGER_VARIABLES   = 4,
  parameter int NUMBER_OF_CLAUSES             = 8,
  parameter int CLAUSE_INDEX_WIDTH            = 3,
  localparam int CW = BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES
) (
  input  logic                          in_clk,
  input  logic                          in_reset_n,
  input  logic                          in_write_enable,
  input  logic [CLAUSE_INDEX_WIDTH-1:0] in_write_index,
  input  logic [CW-1:0]                 in_clause_coefficients,
  input  logic                          in_clear,
  input  logic                          in_start_scan,
  input  logic                          in_stop_scan,
  input  logic                          in_out_ready,
  output logic [CW-1:0]                 out_clause_coefficients,
  output logic [CLAUSE_INDEX_WIDTH-1:0] out_clause_index,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          out_busy,
  output logic                          out_scan_done,
  output logic [CLAUSE_INDEX_WIDTH:0]   out_valid_count
);
  localparam int N  = NUMBER_OF_CLAUSES;
  localparam int IW = CLAUSE_INDEX_WIDTH;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Result of searching the valid vector from a lower bound upwards.
  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
    logic          last;   // no further valid slot above idx
  } find_t;

  function automatic find_t find_from(input logic [N-1:0] v, input int lo);
    find_t r;
    r      = '0;
    r.last = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && i >= lo) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.idx   = IW'(i);
        end else begin
          r.last  = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t                r_state;
  logic [N-1:0][CW-1:0]  r_mem;
  logic [N-1:0]          r_vld;
  logic [CW-1:0]         r_out_data;
  logic [IW-1:0]         r_out_idx;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;
  logic [IW:0]           r_count;

  logic                  w_clr;
  logic                  w_wr_hit;
  logic [N-1:0]          w_sel;
  logic [N-1:0]          w_vld_nxt;
  logic [N-1:0][CW-1:0]  w_mem_nxt;
  logic [IW:0]           w_count_nxt;
  find_t                 w_first;
  find_t                 w_next;
  find_t                 w_ld;
  logic [CW-1:0]         w_ld_data;

  // Clear only acts in IDLE and then also swallows a coincident write.
  assign w_clr    = in_clear && (r_state == S_IDLE);
  assign w_wr_hit = in_write_enable && !w_clr &&
                    ({1'b0, in_write_index} < (IW+1)'(N));

  // Per-slot storage. Searches and loads look at the post-write view so a
  // write landing on the same edge as a load is already visible.
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_sel[g]     = w_wr_hit && (in_write_index == IW'(g));
    assign w_vld_nxt[g] = w_clr ? 1'b0 : (r_vld[g] | w_sel[g]);
    assign w_mem_nxt[g] = w_sel[g] ? in_clause_coefficients : r_mem[g];

    always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
        r_mem[g] <= '0;
        r_vld[g] <= 1'b0;
      end else begin
        r_mem[g] <= w_mem_nxt[g];
        r_vld[g] <= w_vld_nxt[g];
      end
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < N; i++) w_count_nxt = w_count_nxt + (IW+1)'(w_vld_nxt[i]);
  end

  assign w_first = find_from(w_vld_nxt, 0);
  assign w_next  = find_from(w_vld_nxt, int'(r_out_idx) + 1);

  // Next clause to load: advance after a non-last clause, otherwise start
  // (or wrap) at the lowest valid slot.
  always_comb begin
    w_ld = w_first;
    if (r_state == S_SCAN && !r_out_last) w_ld = w_next;
  end

  always_comb begin
    w_ld_data = '0;
    for (int i = 0; i < N; i++)
      if (w_ld.idx == IW'(i)) w_ld_data = w_mem_nxt[i];
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state     <= S_IDLE;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_start_scan) begin
            if (w_first.found) begin
              r_state     <= S_SCAN;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_out_idx   <= w_ld.idx;
              r_out_last  <= w_ld.last;
              r_out_data  <= w_ld_data;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (in_stop_scan) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (r_out_valid && in_out_ready) begin
`ifdef CLAUSE_REGISTER_BANK_CONTINUOUS_SCAN_EN
            if (w_ld.found) begin
`else
            if (!r_out_last && w_ld.found) begin
`endif
              r_out_idx  <= w_ld.idx;
              r_out_last <= w_ld.last;
              r_out_data <= w_ld_data;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_clause_coefficients = r_out_data;
  assign out_clause_index        = r_out_idx;
  assign out_valid               = r_out_valid;
  assign out_last                = r_out_last;
  assign out_busy                = r_busy;
  assign out_scan_done           = r_done;
  assign out_valid_count         = r_count;

endmodule

// File: tb/tb_clause_register_bank.sv
// ---------------------------------------------------------------------------
// tb_clause_register_bank
//   Directed bench for clause_register_bank. The index is one bit wider than
//   the depth needs so that an out-of-range slot (9) can be addressed.
// ---------------------------------------------------------------------------
module tb_clause_register_bank;
  localparam int BW = 8;
  localparam int NV = 4;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam int CW = BW * NV;
`ifdef CLAUSE_REGISTER_BANK_CONTINUOUS_SCAN_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [IW-1:0] widx;
  logic [CW-1:0] wdata;
  logic          clr, start, stop, rdy;
  logic [CW-1:0] odata;
  logic [IW-1:0] oidx;
  logic          ov, olast, obusy, odone;
  logic [IW:0]   ocnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clause_register_bank #(
    .BIT_WIDTH_OF_INTEGER_VARIABLE(BW),
    .NUMBER_OF_INTEGER_VARIABLES  (NV),
    .NUMBER_OF_CLAUSES            (N),
    .CLAUSE_INDEX_WIDTH           (IW)
  ) dut (
    .in_clk                 (clk),
    .in_reset_n             (rst_n),
    .in_write_enable        (we),
    .in_write_index         (widx),
    .in_clause_coefficients (wdata),
    .in_clear               (clr),
    .in_start_scan          (start),
    .in_stop_scan           (stop),
    .in_out_ready           (rdy),
    .out_clause_coefficients(odata),
    .out_clause_index       (oidx),
    .out_valid              (ov),
    .out_last               (olast),
    .out_busy               (obusy),
    .out_scan_done          (odone),
    .out_valid_count        (ocnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [CW-1:0] d);
    we = 1'b1; widx = idx; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic chk_pres(input string tag, input logic [IW-1:0] idx,
                          input logic [CW-1:0] d, input logic last);
    check({tag, "_valid"}, 32'(ov), 32'd1);
    check({tag, "_idx"},   32'(oidx), 32'(idx));
    check({tag, "_data"},  odata, d);
    check({tag, "_last"},  32'(olast), 32'(last));
    check({tag, "_busy"},  32'(obusy), 32'd1);
  endtask

  task automatic chk_end(input string tag);
    check({tag, "_valid"}, 32'(ov), 32'd0);
    check({tag, "_busy"},  32'(obusy), 32'd0);
    check({tag, "_done"},  32'(odone), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; widx = '0; wdata = '0;
    clr = 1'b0; start = 1'b0; stop = 1'b0; rdy = 1'b0;
    #1;
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_busy",  32'(obusy), 32'd0);
    check("rst_done",  32'(odone), 32'd0);
    check("rst_cnt",   32'(ocnt), 32'd0);
    check("rst_data",  odata, 32'd0);
    check("rst_idx",   32'(oidx), 32'd0);
    check("rst_last",  32'(olast), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic two-clause scan, consumer always ready
    wr(4'd2, 32'h0A0B0C0D);
    wr(4'd5, 32'h01020304);
    check("t1_cnt", 32'(ocnt), 32'd2);
    start = 1'b1; rdy = 1'b1;
    tick(); start = 1'b0;
    chk_pres("t1_p0", 4'd2, 32'h0A0B0C0D, 1'b0);
    tick();
    chk_pres("t1_p1", 4'd5, 32'h01020304, 1'b1);
    stop = CONT;
    tick(); stop = 1'b0;
    chk_end("t1_end");
    tick();
    check("t1_done_low", 32'(odone), 32'd0);
    check("t1_cnt2", 32'(ocnt), 32'd2);

    // Back-pressure stability, writes during scan
    rdy = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk_pres("t2_p0", 4'd2, 32'h0A0B0C0D, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_pres("t2_hold", 4'd2, 32'h0A0B0C0D, 1'b0);
    end
    wr(4'd6, 32'hFFFFFFFF);
    check("t2_cnt3", 32'(ocnt), 32'd3);
    chk_pres("t2_after_w6", 4'd2, 32'h0A0B0C0D, 1'b0);
    wr(4'd2, 32'h11111111);
    check("t2_cnt_rewrite", 32'(ocnt), 32'd3);
    chk_pres("t2_after_w2", 4'd2, 32'h0A0B0C0D, 1'b0);
    rdy = 1'b1;
    tick();
    chk_pres("t2_p1", 4'd5, 32'h01020304, 1'b0);
    tick();
    chk_pres("t2_p2", 4'd6, 32'hFFFFFFFF, 1'b1);
    stop = CONT;
    tick(); stop = 1'b0;
    chk_end("t2_end");
    rdy = 1'b0;
    tick();

    // Clear, then scan with nothing valid
    clr = 1'b1;
    tick(); clr = 1'b0;
    check("t3_cnt", 32'(ocnt), 32'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("t3_valid", 32'(ov), 32'd0);
    check("t3_busy",  32'(obusy), 32'd0);
    check("t3_done",  32'(odone), 32'd1);
    tick();
    check("t3_done_low", 32'(odone), 32'd0);
    check("t3_valid2",   32'(ov), 32'd0);

    // Out-of-range write, clear beats write, stop priority
    wr(4'd9, 32'hDEADBEEF);
    check("t5_oor_cnt", 32'(ocnt), 32'd0);
    clr = 1'b1; we = 1'b1; widx = 4'd1; wdata = 32'h12345678;
    tick(); clr = 1'b0; we = 1'b0;
    check("t5_clrwr_cnt", 32'(ocnt), 32'd0);
    wr(4'd1, 32'hC0C0C0C0);
    wr(4'd3, 32'hD0D0D0D0);
    wr(4'd4, 32'hE0E0E0E0);
    check("t5_cnt3", 32'(ocnt), 32'd3);
    rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk_pres("t5_p0", 4'd1, 32'hC0C0C0C0, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    chk_end("t5_stop");
    tick();
    check("t5_done_low", 32'(odone), 32'd0);
    check("t5_valid_low", 32'(ov), 32'd0);
    check("t5_cnt_keep", 32'(ocnt), 32'd3);
    rdy = 1'b0;

`ifdef CLAUSE_REGISTER_BANK_CONTINUOUS_SCAN_EN
    // Continuous wrap over slots 1 and 3
    clr = 1'b1;
    tick(); clr = 1'b0;
    wr(4'd1, 32'hC0C0C0C0);
    wr(4'd3, 32'hD0D0D0D0);
    rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk_pres("t6_a", 4'd1, 32'hC0C0C0C0, 1'b0);
      tick();
      chk_pres("t6_b", 4'd3, 32'hD0D0D0D0, 1'b1);
      tick();
    end
    chk_pres("t6_wrap", 4'd1, 32'hC0C0C0C0, 1'b0);
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk_end("t6_stop");
    rdy = 1'b0;
`endif

    // Reset in the middle of a scan
    rdy = CONT; start = 1'b1;
    tick(); start = 1'b0;
    check("t7_valid_pre", 32'(ov), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", 32'(ov), 32'd0);
    check("t7_busy",  32'(obusy), 32'd0);
    check("t7_done",  32'(odone), 32'd0);
    check("t7_cnt",   32'(ocnt), 32'd0);
    check("t7_idx",   32'(oidx), 32'd0);
    check("t7_data",  odata, 32'd0);
    check("t7_last",  32'(olast), 32'd0);
    tick();
    check("t7_done_held", 32'(odone), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t7_done_rel", 32'(odone), 32'd0);
    check("t7_cnt_rel",  32'(ocnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
